// File: rtl/udma_evt_queue.sv
// uDMA event queue: FIFO between the SoC event bus and uDMA control event compare.
// Optional macro UDMA_EVT_QUEUE_DROP_CNT_EN adds the saturating drop_cnt_o counter.
module udma_evt_queue #(
    parameter int DEPTH        = 8,
    parameter int EVT_W        = 8,
    parameter int DROP_ON_FULL = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    input  logic [EVT_W-1:0]         in_data_i,
    output logic                     in_ready_o,
    output logic                     out_valid_o,
    output logic [EVT_W-1:0]         out_data_o,
    input  logic                     out_ready_i,
    input  logic                     clr_ovf_i,
    output logic                     ovf_o,
`ifdef UDMA_EVT_QUEUE_DROP_CNT_EN
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [7:0]               drop_cnt_o
`else
    output logic [$clog2(DEPTH):0]   level_o
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [EVT_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    logic             ovf_q;

    // The pointer MSB separates the full case from the empty case.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign pop = ~empty & out_ready_i;

    // In drop mode a full queue still takes an event when the head leaves.
    assign push = (DROP_ON_FULL != 0) ? (in_valid_i & (~full | pop))
                                      : (in_valid_i & ~full);

    assign drop = (DROP_ON_FULL != 0) & in_valid_i & full & ~pop;

    assign in_ready_o  = (DROP_ON_FULL != 0) ? 1'b1 : ~full;
    assign out_valid_o = ~empty;
    assign out_data_o  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign level_o     = wr_ptr - rd_ptr;
    assign ovf_o       = ovf_q;

    // Event storage; only written on an accepted push.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data_i;
        end
    end

    // Read/write pointers, wrapping modulo 2*DEPTH.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Sticky overflow flag; a drop in the clear cycle keeps it set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf_i) begin
            ovf_q <= 1'b0;
        end
    end

`ifdef UDMA_EVT_QUEUE_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    assign drop_cnt_o = drop_cnt_q;

    // Saturating drop counter; clear restarts at 1 if a drop coincides.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else if (clr_ovf_i) begin
            drop_cnt_q <= drop ? 8'd1 : 8'd0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end
`endif

endmodule
